lb_sched: RTL and testbench

Line-build scheduler for the double-buffered line buffer BRAM. It ping-pongs the two line-buffer banks on every line start and then owns the draw port for that line. It clears the back bank, then grants the port first to the tile engine and then to the sprite engine. It sits between the VGA timing generator, the two draw engines and the draw port of the line buffer, whose display port reads `{disp_bank, sx}`.

---
 rtl/lb_sched_if.sv | 48 ++++
 rtl/lb_sched.sv | 163 ++++++++++++++++
 tb/tb_lb_sched.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/lb_sched_if.sv
// Line-build scheduler bundle: line timing, draw-engine handshakes, line-buffer draw port.
// Latency: wires only; all timing belongs to the modules on either side.
// Backpressure: none; engines write at will, and the scheduler filters or forwards.
//
// Ports (master = timing generator / engines side, slave = scheduler side):
//   line_start, frame_start          line timing pulses into the scheduler
//   disp_bank, draw_y                bank being displayed, line being built
//   tile_*/spr_*                     per-engine start/done/write strobes
//   abort, overrun, busy             line status out of the scheduler
//   lb_we, lb_addr, lb_colour        line-buffer draw port
interface lb_sched_if #(
    parameter int CORDW = 11
);
    logic             line_start;
    logic             frame_start;
    logic             disp_bank;
    logic [CORDW-1:0] draw_y;
    logic             tile_start;
    logic             spr_start;
    logic             tile_done;
    logic             spr_done;
    logic             tile_we;
    logic             spr_we;
    logic [CORDW-2:0] tile_x;
    logic [CORDW-2:0] spr_x;
    logic [7:0]       tile_colour;
    logic [7:0]       spr_colour;
    logic             abort;
    logic             overrun;
    logic             busy;
    logic             lb_we;
    logic [CORDW-1:0] lb_addr;
    logic [7:0]       lb_colour;

    modport master (
        output line_start, frame_start, tile_done, spr_done,
               tile_we, spr_we, tile_x, spr_x, tile_colour, spr_colour,
        input  disp_bank, draw_y, tile_start, spr_start,
               abort, overrun, busy, lb_we, lb_addr, lb_colour
    );

    modport slave (
        input  line_start, frame_start, tile_done, spr_done,
               tile_we, spr_we, tile_x, spr_x, tile_colour, spr_colour,
        output disp_bank, draw_y, tile_start, spr_start,
               abort, overrun, busy, lb_we, lb_addr, lb_colour
    );
endinterface

// File: rtl/lb_sched.sv
// Line-build scheduler: ping-pong line-buffer banks, clear back bank, then grant tile then sprite engine.
// Latency: all outputs registered; engine write -> lb_* one cycle later, line_start -> first clear write one cycle later.
// Backpressure: none; out-of-range, transparent or non-granted writes are dropped, and a late line is aborted.
//
// Ports:
//   clk_pix    pixel clock
//   rst_pix_n  asynchronous active-low reset
//   bus        lb_sched_if slave: line timing in, engine handshakes, line-buffer draw port out
module lb_sched #(
    parameter int         CORDW        = 11,
    parameter int         LINE_W       = 640,
    parameter int         LINES        = 525,
    parameter logic [7:0] CLEAR_COLOUR = 8'h00
) (
    input  logic     clk_pix,
    input  logic     rst_pix_n,
    lb_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, TILE, SPRITE, DONE} state_t;

    localparam logic [CORDW-1:0] LINE_W_C = CORDW'(LINE_W);
    localparam logic [CORDW-2:0] LAST_X   = (CORDW-1)'(LINE_W - 1);
    localparam logic [CORDW-2:0] ONE_X    = (CORDW-1)'(1);
    localparam logic [CORDW-1:0] LAST_Y   = CORDW'(LINES - 1);
    localparam logic [CORDW-1:0] ONE_Y    = CORDW'(1);

    state_t           state, state_n;
    logic [CORDW-2:0] cx, cx_n;          // x of the clear write currently on lb_*
    logic             bank_q, bank_n;
    logic [CORDW-1:0] y_q, y_n;
    logic             we_q, we_n;
    logic [CORDW-2:0] wx_n;
    logic [7:0]       col_n;
    logic [CORDW-1:0] addr_q;
    logic [7:0]       col_q;
    logic             tstart_q, tstart_n;
    logic             sstart_q, sstart_n;
    logic             ovr_q, ovr_n;
    logic             busy_q, busy_n;
    logic             tile_ok, spr_ok;

    // Engine write qualification: in range, and sprites must not be transparent.
    assign tile_ok = bus.tile_we && ({1'b0, bus.tile_x} < LINE_W_C);
    assign spr_ok  = bus.spr_we && ({1'b0, bus.spr_x} < LINE_W_C) &&
                     (bus.spr_colour != CLEAR_COLOUR);

    // Next-state and next-output logic. The draw-port registers are loaded
    // from the transition being taken, so a clear write for x=0 is already
    // on lb_* in the first CLEAR cycle.
    always_comb begin
        state_n  = state;
        cx_n     = cx;
        bank_n   = bank_q;
        y_n      = y_q;
        we_n     = 1'b0;
        wx_n     = '0;
        col_n    = CLEAR_COLOUR;
        tstart_n = 1'b0;
        sstart_n = 1'b0;
        ovr_n    = 1'b0;

        if (bus.line_start) begin
            // Line start wins over any done/write in the same cycle.
            bank_n  = ~bank_q;
            if (bus.frame_start || (y_q == LAST_Y)) begin
                y_n = '0;
            end else begin
                y_n = y_q + ONE_Y;
            end
            ovr_n   = (state == CLEAR) || (state == TILE) || (state == SPRITE);
            cx_n    = '0;
            state_n = CLEAR;
            we_n    = 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cx == LAST_X) begin
                        state_n  = TILE;
                        tstart_n = 1'b1;
                    end else begin
                        cx_n = cx + ONE_X;
                        we_n = 1'b1;
                        wx_n = cx + ONE_X;
                    end
                end
                TILE: begin
                    if (tile_ok) begin
                        we_n  = 1'b1;
                        wx_n  = bus.tile_x;
                        col_n = bus.tile_colour;
                    end
                    if (bus.tile_done) begin
                        state_n  = SPRITE;
                        sstart_n = 1'b1;
                    end
                end
                SPRITE: begin
                    if (spr_ok) begin
                        we_n  = 1'b1;
                        wx_n  = bus.spr_x;
                        col_n = bus.spr_colour;
                    end
                    if (bus.spr_done) begin
                        state_n = DONE;
                    end
                end
                default: begin
                end
            endcase
        end

        busy_n = (state_n == CLEAR) || (state_n == TILE) || (state_n == SPRITE);
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            cx       <= '0;
            bank_q   <= 1'b0;
            y_q      <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            col_q    <= '0;
            tstart_q <= 1'b0;
            sstart_q <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            cx       <= cx_n;
            bank_q   <= bank_n;
            y_q      <= y_n;
            we_q     <= we_n;
            tstart_q <= tstart_n;
            sstart_q <= sstart_n;
            ovr_q    <= ovr_n;
            busy_q   <= busy_n;
            // Address/colour only move with a write; the bank bit is taken
            // from the next display bank so it is never the displayed one.
            if (we_n) begin
                addr_q <= {~bank_n, wx_n};
                col_q  <= col_n;
            end
        end
    end

    assign bus.disp_bank  = bank_q;
    assign bus.draw_y     = y_q;
    assign bus.tile_start = tstart_q;
    assign bus.spr_start  = sstart_q;
    assign bus.abort      = ovr_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = busy_q;
    assign bus.lb_we      = we_q;
    assign bus.lb_addr    = addr_q;
    assign bus.lb_colour  = col_q;
endmodule

// File: tb/tb_lb_sched.sv
// Bench for lb_sched: directed line sequences checked against a cycle-window model every cycle.
// Latency: outputs compared 1 time unit after each rising edge; literal checks 2 units after.
// Backpressure: none on the design; the bench drives strobes freely.
module tb_lb_sched;
    localparam int CORDW  = 11;
    localparam int LINE_W = 8;
    localparam int LINES  = 4;
    localparam int BIG    = 1 << 30;

    localparam int P_IDLE = 0;
    localparam int P_CLR  = 1;
    localparam int P_TILE = 2;
    localparam int P_SPR  = 3;
    localparam int P_DONE = 4;

    logic clk_pix   = 1'b0;
    logic rst_pix_n = 1'b0;

    always #5 clk_pix = ~clk_pix;

    lb_sched_if #(.CORDW(CORDW)) bus ();

    lb_sched #(
        .CORDW       (CORDW),
        .LINE_W      (LINE_W),
        .LINES       (LINES),
        .CLEAR_COLOUR(8'h00)
    ) dut (
        .clk_pix  (clk_pix),
        .rst_pix_n(rst_pix_n),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a line is a set of cycle windows measured from its line_start.
    // ls = line_start cycle, tdone/sdone = cycle the done was accepted.
    int cyc = 0;
    int ls = 0, tdone = BIG, sdone = BIG;
    bit has_line = 0;
    bit m_bank = 0;
    int m_y = 0;
    bit pend_we = 0;
    int pend_x = 0, pend_col = 0;

    function automatic int phase(input int c);
        if (!has_line || c <= ls) return P_IDLE;
        if (c <= ls + LINE_W)     return P_CLR;
        if (c <= tdone)           return P_TILE;
        if (c <= sdone)           return P_SPR;
        return P_DONE;
    endfunction

    always @(posedge clk_pix) begin
        int ph;
        bit e_abort, e_we;
        int e_addr, e_col;
        e_abort = 1'b0;
        if (!rst_pix_n) begin
            has_line = 0; m_bank = 0; m_y = 0; pend_we = 0;
            tdone = BIG; sdone = BIG;
        end else begin
            ph = phase(cyc);
            pend_we = 0;
            if (bus.line_start) begin
                e_abort  = (ph == P_CLR) || (ph == P_TILE) || (ph == P_SPR);
                m_bank   = ~m_bank;
                m_y      = bus.frame_start ? 0 : (m_y + 1) % LINES;
                has_line = 1; ls = cyc; tdone = BIG; sdone = BIG;
            end else if (ph == P_TILE) begin
                if (bus.tile_we && int'(bus.tile_x) < LINE_W) begin
                    pend_we = 1; pend_x = int'(bus.tile_x); pend_col = int'(bus.tile_colour);
                end
                if (bus.tile_done) tdone = cyc;
            end else if (ph == P_SPR) begin
                if (bus.spr_we && int'(bus.spr_x) < LINE_W && bus.spr_colour != 8'h00) begin
                    pend_we = 1; pend_x = int'(bus.spr_x); pend_col = int'(bus.spr_colour);
                end
                if (bus.spr_done) sdone = cyc;
            end
        end
        cyc++;
        ph = phase(cyc);
        e_we = 0; e_addr = 0; e_col = 0;
        if (ph == P_CLR) begin
            e_we = 1; e_addr = ((m_bank ? 0 : 1) << 10) | (cyc - ls - 1); e_col = 0;
        end else if (pend_we) begin
            e_we = 1; e_addr = ((m_bank ? 0 : 1) << 10) | pend_x; e_col = pend_col;
        end
        #1;
        chk("disp_bank",  32'(bus.disp_bank),  32'(m_bank));
        chk("draw_y",     32'(bus.draw_y),     32'(m_y));
        chk("busy",       32'(bus.busy),       32'((ph == P_CLR) || (ph == P_TILE) || (ph == P_SPR)));
        chk("tile_start", 32'(bus.tile_start), 32'(has_line && (cyc == ls + LINE_W + 1)));
        chk("spr_start",  32'(bus.spr_start),  32'((tdone != BIG) && (cyc == tdone + 1)));
        chk("abort",      32'(bus.abort),      32'(e_abort));
        chk("overrun",    32'(bus.overrun),    32'(e_abort));
        chk("lb_we",      32'(bus.lb_we),      32'(e_we));
        if (e_we) begin
            chk("lb_addr",   32'(bus.lb_addr),   32'(e_addr));
            chk("lb_colour", 32'(bus.lb_colour), 32'(e_col));
        end
    end

    task automatic tick();
        @(posedge clk_pix);
        #2;
        bus.line_start  = 1'b0;
        bus.frame_start = 1'b0;
        bus.tile_done   = 1'b0;
        bus.spr_done    = 1'b0;
        bus.tile_we     = 1'b0;
        bus.spr_we      = 1'b0;
    endtask

    task automatic tile_wr(input int x, input logic [7:0] c);
        bus.tile_we = 1'b1; bus.tile_x = (CORDW-1)'(x); bus.tile_colour = c;
    endtask

    task automatic spr_wr(input int x, input logic [7:0] c);
        bus.spr_we = 1'b1; bus.spr_x = (CORDW-1)'(x); bus.spr_colour = c;
    endtask

    initial begin
        int exp_y[4] = '{1, 2, 3, 0};
        bus.line_start = 0; bus.frame_start = 0; bus.tile_done = 0; bus.spr_done = 0;
        bus.tile_we = 0; bus.spr_we = 0; bus.tile_x = '0; bus.spr_x = '0;
        bus.tile_colour = '0; bus.spr_colour = '0;

        // Reset state, then idle writes are ignored.
        tick(); tick();
        chk("rst disp_bank", 32'(bus.disp_bank), 32'd0);
        chk("rst lb_we",     32'(bus.lb_we),     32'd0);
        rst_pix_n = 1'b1;
        tile_wr(1, 8'h55);
        tick();
        chk("idle lb_we", 32'(bus.lb_we), 32'd0);
        tick(); tick();

        // Reset in the middle of a clear.
        bus.line_start = 1; bus.frame_start = 1;
        tick();
        chk("lineA disp_bank", 32'(bus.disp_bank), 32'd1);
        chk("lineA lb_we",     32'(bus.lb_we),     32'd1);
        tick(); tick();
        rst_pix_n = 1'b0;
        #1;
        chk("async rst disp_bank", 32'(bus.disp_bank), 32'd0);
        chk("async rst lb_we",     32'(bus.lb_we),     32'd0);
        chk("async rst busy",      32'(bus.busy),      32'd0);
        chk("async rst lb_addr",   32'(bus.lb_addr),   32'd0);
        tick(); tick();
        rst_pix_n = 1'b1;
        tick(); tick(); tick();
        chk("post rst lb_we", 32'(bus.lb_we), 32'd0);

        // Clear, tile pass, sprite pass.
        bus.line_start = 1; bus.frame_start = 1;
        tick();
        chk("clr disp_bank", 32'(bus.disp_bank), 32'd1);
        chk("clr addr0",     32'(bus.lb_addr),   32'h000);
        chk("clr busy",      32'(bus.busy),      32'd1);
        repeat (7) tick();
        chk("clr addr7", 32'(bus.lb_addr), 32'h007);
        tick();
        chk("tile_start", 32'(bus.tile_start), 32'd1);
        chk("tile entry we", 32'(bus.lb_we), 32'd0);
        tile_wr(3, 8'h5A);
        tick();
        chk("tile wr addr", 32'(bus.lb_addr),   32'h003);
        chk("tile wr col",  32'(bus.lb_colour), 32'h5A);
        tile_wr(8, 8'h11);
        tick();
        chk("tile x8 drop", 32'(bus.lb_we), 32'd0);
        tile_wr(7, 8'h77); bus.tile_done = 1;
        tick();
        chk("done wr addr", 32'(bus.lb_addr),   32'h007);
        chk("spr_start",    32'(bus.spr_start), 32'd1);
        spr_wr(2, 8'h00); tile_wr(4, 8'h44);
        tick();
        chk("transparent drop", 32'(bus.lb_we), 32'd0);
        spr_wr(2, 8'hC3);
        tick();
        chk("spr wr addr", 32'(bus.lb_addr),   32'h002);
        chk("spr wr col",  32'(bus.lb_colour), 32'hC3);
        bus.spr_done = 1;
        tick();
        chk("spr done busy", 32'(bus.busy), 32'd0);
        bus.tile_done = 1; spr_wr(1, 8'h99);
        tick();
        chk("done idle we", 32'(bus.lb_we), 32'd0);

        // Overrun during TILE, with a simultaneous write that must be dropped.
        bus.line_start = 1;
        tick();
        chk("ovr line addr", 32'(bus.lb_addr), 32'h400);
        chk("ovr line y",    32'(bus.draw_y),  32'd1);
        repeat (8) tick();
        chk("ovr tile_start", 32'(bus.tile_start), 32'd1);
        bus.line_start = 1; tile_wr(5, 8'h66);
        tick();
        chk("abort",        32'(bus.abort),     32'd1);
        chk("overrun",      32'(bus.overrun),   32'd1);
        chk("ovr bank",     32'(bus.disp_bank), 32'd1);
        chk("ovr clr addr", 32'(bus.lb_addr),   32'h000);
        tick();
        chk("abort pulse", 32'(bus.abort), 32'd0);

        // Line counting with wrap.
        bus.line_start = 1; bus.frame_start = 1;
        tick();
        chk("frame y", 32'(bus.draw_y), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); tick();
            bus.line_start = 1;
            tick();
            chk("line y", 32'(bus.draw_y), 32'(exp_y[i]));
        end
        repeat (14) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
